ccff_chain_loader: RTL and testbench
====================================

# ccff_chain_loader

Configuration-chain loader for the `fpga_top` fabric. It accepts a bitstream as a valid/ready stream of one bit per chain per beat and shifts it into the `ccff_head` inputs of all configuration chains in parallel. It then reads the chains back by recirculating `ccff_tail` into `ccff_head` and checks per-chain parity. Finally it holds the fabric in reset for a settle window before releasing it. It sits between the bitstream source (ROM/SPI front end) and the fabric's configuration ports, in the `prog_clk` domain.

## Interface
- `NUM_CHAINS`, 8, number of configuration chains driven in parallel
- `CHAIN_LEN`, 4096, flip-flops per chain (all chains equal length, padded by the bitstream generator)
- `SETTLE_CYC`, 16, cycles of fabric reset held after a successful verify; must be ≥1
- One clock; reset is synchronous and active-high. `prog_clk` is the clock and `prog_reset` is the reset.
- `prog_clk`  in  1  configuration clock, the only clock of the block
- `prog_reset`  in  1  synchronous active-high reset
- `start`  in  1  single-cycle pulse; begins a load from IDLE, DONE or ERROR, ignored otherwise
- `abort`  in  1  returns to IDLE from any state; has priority over `start`
- `bs_valid`  in  1  bitstream beat valid
- `bs_ready`  out  1  beat accepted when `bs_valid & bs_ready`
- `bs_data`  in  NUM_CHAINS  bit i goes to chain i
- `ccff_head`  out  NUM_CHAINS  serial input to each chain
- `ccff_tail`  in  NUM_CHAINS  serial output of each chain
- `ccff_shift_en`  out  1  enable for the external chain clock gate; chains shift on the `prog_clk` edge where it is high
- `config_enable`  out  1  high during LOAD and VERIFY
- `fabric_reset`  out  1  drives the fabric `reset` bus; high except in DONE
- `cfg_done`  out  1  high in DONE
- `cfg_err`  out  NUM_CHAINS  sticky per-chain parity mismatch; cleared on `start` or reset

## Operation
- States: IDLE, LOAD, VERIFY, SETTLE, DONE, ERROR.
- On reset, the state is IDLE, counters are 0 and parity registers are 0. Outputs on reset: `bs_ready`=0, `ccff_shift_en`=0, `ccff_head`=0, `config_enable`=0, `fabric_reset`=1, `cfg_done`=0, `cfg_err`=0.
- IDLE/DONE/ERROR + `start` → LOAD. This clears `beat_cnt`, `load_par`, `ver_par` and `cfg_err`.
- **LOAD**
  - `bs_ready`=1.
  - `ccff_head`=`bs_data`.
  - `ccff_shift_en`=`bs_valid`.
  - On each accepted beat: `load_par ^= bs_data` and `beat_cnt++`.
  - The accepted beat with `beat_cnt==CHAIN_LEN-1` → VERIFY, with `beat_cnt` cleared.
  - Stalls (`bs_valid`=0) hold all state and do not shift.
- **VERIFY**
  - `ccff_head`=`ccff_tail` (recirculate).
  - `ccff_shift_en`=1 every cycle.
  - Each cycle: `ver_par ^= ccff_tail`.
  - After exactly CHAIN_LEN cycles the chain contents are back to the loaded image.
  - On the last cycle, the final `ver_par` (including that cycle's tail bit) is compared with `load_par`.
  - Any mismatch → ERROR, with `cfg_err` = the mismatch mask. Otherwise → SETTLE.
- **SETTLE**
  - `fabric_reset`=1, `config_enable`=0.
  - Counts SETTLE_CYC cycles, then → DONE.
- **DONE**
  - `fabric_reset`=0, `cfg_done`=1.
  - Stays in DONE until `start`, `abort` or reset.
- **ERROR**
  - `fabric_reset`=1, `cfg_err` held.
  - Left only via `start`, `abort` or reset.
- **abort** (any state): next state is IDLE. `fabric_reset`=1 and `cfg_err` is cleared. The partial chain contents are undefined and a new `start` is required.
- `beat_cnt` width is `$clog2(CHAIN_LEN)`. With CHAIN_LEN a power of two, the terminal compare is on CHAIN_LEN-1, never on wrap.

## Timing
- `start` sampled high at edge N → LOAD from N+1, so `bs_ready` rises in cycle N+1.
- `ccff_head`, `ccff_shift_en` and `bs_ready` are combinational from state and `bs_valid`. All other outputs are registered, decoded from state.
- Minimum total latency from `start` to `cfg_done` is 1 + CHAIN_LEN (LOAD, no stalls) + CHAIN_LEN (VERIFY) + SETTLE_CYC cycles.
- `start` and `abort` in the same cycle: `abort` wins.
- `prog_reset` mid-load behaves exactly like `abort` plus clearing all counters.

## Structure
- A shared package `ccff_loader_pkg` holds the state enum `ccff_ld_state_e` and the default parameter constants.
- One sub-module, `ccff_parity_acc`: a NUM_CHAINS-wide XOR accumulator with clear and enable inputs. It is instantiated twice, once for `load_par` and once for `ver_par`.

## Test plan
- **Clean load** (CHAIN_LEN=8, NUM_CHAINS=8, SETTLE_CYC=4, chain model = 8-deep shift registers, no stalls, random data) → 8 shifts in LOAD, 8 in VERIFY, chains equal the loaded image, and `cfg_done`=1 exactly 21 cycles after `start`.
- **Source stalls**: `bs_valid` toggling 1,0,0,1… → `ccff_shift_en` high only on accepted beats, and the final image is correct.
- **Fault injection**: stuck-at-0 on chain 3, with an odd-parity pattern loaded on chain 3 → ERROR, `cfg_err`=8'b0000_1000, `fabric_reset` stays 1.
- **Abort mid-load**: `abort` at beat 5 → IDLE next cycle, `bs_ready`=0, `fabric_reset`=1.
- **Start while busy**: `start` pulsed during VERIFY → ignored and the sequence completes normally. A later `start` from DONE reloads and clears `cfg_done`.
- **Reset mid-VERIFY**: `prog_reset` asserted → all outputs return to their reset values on the next edge.

Source files
------------

// File: rtl/ccff_chain_loader_pkg.sv
// Shared types and default sizing for the configuration-chain loader.
// The enum encodes the load / verify / settle sequencing states.
package ccff_loader_pkg;

    localparam int DEF_NUM_CHAINS = 8;
    localparam int DEF_CHAIN_LEN  = 4096;
    localparam int DEF_SETTLE_CYC = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_VERIFY,
        ST_SETTLE,
        ST_DONE,
        ST_ERROR
    } ccff_ld_state_e;

    // States from which a start pulse may launch a new load.
    function automatic logic can_start(ccff_ld_state_e s);
        return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERROR);
    endfunction

endpackage

// File: rtl/ccff_chain_loader_if.sv
// Bitstream stream port: one bit per chain per beat, valid/ready handshake.
interface ccff_bs_if
    import ccff_loader_pkg::*;
#(
    parameter int NUM_CHAINS = DEF_NUM_CHAINS
) ();
    logic                  bs_valid;
    logic                  bs_ready;
    logic [NUM_CHAINS-1:0] bs_data;

    modport master (output bs_valid, output bs_data, input bs_ready);
    modport slave  (input bs_valid, input bs_data, output bs_ready);
endinterface

// File: rtl/ccff_chain_loader_parity_acc.sv
// Per-chain XOR accumulator with synchronous clear and enable.
module ccff_parity_acc #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] par
);
    logic [W-1:0] par_reg;

    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_bit
            always_ff @(posedge clk) begin
                if (srst || clr)
                    par_reg[gi] <= 1'b0;
                else if (en)
                    par_reg[gi] <= par_reg[gi] ^ din[gi];
            end
        end
    endgenerate

    assign par = par_reg;
endmodule

// File: rtl/ccff_chain_loader.sv
// Shifts a bitstream into all configuration chains in parallel, reads it back
// by recirculation with per-chain parity check, then settles and releases reset.
module ccff_chain_loader
    import ccff_loader_pkg::*;
#(
    parameter int NUM_CHAINS = DEF_NUM_CHAINS,
    parameter int CHAIN_LEN  = DEF_CHAIN_LEN,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
    input  logic                  prog_clk,
    input  logic                  prog_reset,
    input  logic                  start,
    input  logic                  abort,
    ccff_bs_if.slave              bs,
    output logic [NUM_CHAINS-1:0] ccff_head,
    input  logic [NUM_CHAINS-1:0] ccff_tail,
    output logic                  ccff_shift_en,
    output logic                  config_enable,
    output logic                  fabric_reset,
    output logic                  cfg_done,
    output logic [NUM_CHAINS-1:0] cfg_err
);
    localparam int CNT_W = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
    localparam int SET_W = $clog2(SETTLE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYC - 1);

    ccff_ld_state_e        state_reg, state_next;
    logic [CNT_W-1:0]      beat_cnt_reg, beat_cnt_next;
    logic [SET_W-1:0]      settle_cnt_reg, settle_cnt_next;
    logic [NUM_CHAINS-1:0] cfg_err_reg, cfg_err_next;
    logic                  config_enable_reg, fabric_reset_reg, cfg_done_reg;
    logic                  par_clr, load_en, ver_en;
    logic [NUM_CHAINS-1:0] load_par, ver_par, mismatch;

    ccff_parity_acc #(.W(NUM_CHAINS)) u_load_par (
        .clk(prog_clk), .srst(prog_reset), .clr(par_clr),
        .en(load_en), .din(bs.bs_data), .par(load_par)
    );

    ccff_parity_acc #(.W(NUM_CHAINS)) u_ver_par (
        .clk(prog_clk), .srst(prog_reset), .clr(par_clr),
        .en(ver_en), .din(ccff_tail), .par(ver_par)
    );

    // Final readback parity must include the tail bit of the last cycle.
    assign mismatch = (ver_par ^ ccff_tail) ^ load_par;

    always_comb begin
        state_next      = state_reg;
        beat_cnt_next   = beat_cnt_reg;
        settle_cnt_next = settle_cnt_reg;
        cfg_err_next    = cfg_err_reg;
        par_clr         = 1'b0;
        load_en         = 1'b0;
        ver_en          = 1'b0;
        case (state_reg)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_next    = ST_LOAD;
                    beat_cnt_next = '0;
                    cfg_err_next  = '0;
                    par_clr       = 1'b1;
                end
            end
            ST_LOAD: begin
                if (bs.bs_valid) begin
                    load_en = 1'b1;
                    if (beat_cnt_reg == CNT_LAST) begin
                        state_next    = ST_VERIFY;
                        beat_cnt_next = '0;
                    end else begin
                        beat_cnt_next = beat_cnt_reg + CNT_W'(1);
                    end
                end
            end
            ST_VERIFY: begin
                ver_en = 1'b1;
                if (beat_cnt_reg == CNT_LAST) begin
                    beat_cnt_next   = '0;
                    settle_cnt_next = '0;
                    if (mismatch != '0) begin
                        state_next   = ST_ERROR;
                        cfg_err_next = mismatch;
                    end else begin
                        state_next = ST_SETTLE;
                    end
                end else begin
                    beat_cnt_next = beat_cnt_reg + CNT_W'(1);
                end
            end
            ST_SETTLE: begin
                if (settle_cnt_reg == SET_LAST)
                    state_next = ST_DONE;
                else
                    settle_cnt_next = settle_cnt_reg + SET_W'(1);
            end
            default: state_next = ST_IDLE;
        endcase
        if (abort) begin
            state_next      = ST_IDLE;
            cfg_err_next    = '0;
            beat_cnt_next   = '0;
            settle_cnt_next = '0;
        end
    end

    // Status outputs are registered from the next state so they line up with state_reg.
    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            state_reg         <= ST_IDLE;
            beat_cnt_reg      <= '0;
            settle_cnt_reg    <= '0;
            cfg_err_reg       <= '0;
            config_enable_reg <= 1'b0;
            fabric_reset_reg  <= 1'b1;
            cfg_done_reg      <= 1'b0;
        end else begin
            state_reg         <= state_next;
            beat_cnt_reg      <= beat_cnt_next;
            settle_cnt_reg    <= settle_cnt_next;
            cfg_err_reg       <= cfg_err_next;
            config_enable_reg <= (state_next == ST_LOAD) || (state_next == ST_VERIFY);
            fabric_reset_reg  <= (state_next != ST_DONE);
            cfg_done_reg      <= (state_next == ST_DONE);
        end
    end

    always_comb begin
        bs.bs_ready   = 1'b0;
        ccff_head     = '0;
        ccff_shift_en = 1'b0;
        case (state_reg)
            ST_LOAD: begin
                bs.bs_ready   = 1'b1;
                ccff_head     = bs.bs_data;
                ccff_shift_en = bs.bs_valid;
            end
            ST_VERIFY: begin
                ccff_head     = ccff_tail;
                ccff_shift_en = 1'b1;
            end
            default: ;
        endcase
    end

    assign config_enable = config_enable_reg;
    assign fabric_reset  = fabric_reset_reg;
    assign cfg_done      = cfg_done_reg;
    assign cfg_err       = cfg_err_reg;
endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: behavioural chain model plus image/parity reference.
module tb_ccff_chain_loader;
    import ccff_loader_pkg::*;

    localparam int NC = 8;
    localparam int CL = 8;
    localparam int SC = 4;

    logic          prog_clk = 1'b0;
    logic          prog_reset = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [NC-1:0] ccff_head, ccff_tail, cfg_err;
    logic          ccff_shift_en, config_enable, fabric_reset, cfg_done;

    int tests = 0;
    int failed = 0;
    int cyc = 0;

    logic [NC-1:0] beats [CL];
    logic [CL-1:0] chain_mem [NC];
    logic [NC-1:0] stuck = '0;

    ccff_bs_if #(.NUM_CHAINS(NC)) bs_if ();

    ccff_chain_loader #(.NUM_CHAINS(NC), .CHAIN_LEN(CL), .SETTLE_CYC(SC)) dut (
        .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start), .abort(abort),
        .bs(bs_if.slave), .ccff_head(ccff_head), .ccff_tail(ccff_tail),
        .ccff_shift_en(ccff_shift_en), .config_enable(config_enable),
        .fabric_reset(fabric_reset), .cfg_done(cfg_done), .cfg_err(cfg_err)
    );

    always #5 prog_clk = ~prog_clk;
    always @(posedge prog_clk) cyc <= cyc + 1;

    // External chains: CL-deep shift registers, optional stuck-at-0 output.
    always_comb begin
        for (int i = 0; i < NC; i++)
            ccff_tail[i] = chain_mem[i][CL-1] & ~stuck[i];
    end
    always @(posedge prog_clk) begin
        if (ccff_shift_en)
            for (int i = 0; i < NC; i++)
                chain_mem[i] <= {chain_mem[i][CL-2:0], ccff_head[i]};
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: first accepted beat ends up at the chain's far end.
    function automatic logic [CL-1:0] model_image(input int ch);
        logic [CL-1:0] v;
        for (int k = 0; k < CL; k++) v[CL-1-k] = beats[k][ch];
        return v;
    endfunction

    function automatic logic model_par(input int ch);
        logic p = 1'b0;
        for (int k = 0; k < CL; k++) p ^= beats[k][ch];
        return p;
    endfunction

    function automatic int image_bad();
        int n = 0;
        for (int i = 0; i < NC; i++) if (chain_mem[i] !== model_image(i)) n++;
        return n;
    endfunction

    task automatic new_beats();
        for (int k = 0; k < CL; k++) beats[k] = NC'($urandom);
    endtask

    task automatic pulse_start();
        @(negedge prog_clk);
        start = 1'b1;
        @(negedge prog_clk);
        start = 1'b0;
    endtask

    // Start, stream the beats (optionally stalling 1,0,0,...), then wait for DONE or ERROR.
    task automatic run_seq(input int stall_mode, input int busy_at,
                           output int latency, output int shifts, output int en_bad,
                           output int load_cycles, output logic first_done);
        int t0, k, idx;
        logic v;
        @(negedge prog_clk);
        start = 1'b1;
        t0 = cyc;
        @(negedge prog_clk);
        start = 1'b0;
        first_done = cfg_done;
        shifts = 0; en_bad = 0; k = 0; idx = 0;
        while (k < CL && idx < 200) begin
            v = (stall_mode != 0) ? (idx % 3 == 0) : 1'b1;
            bs_if.bs_valid = v;
            bs_if.bs_data  = v ? beats[k] : NC'($urandom);
            #1;
            if (ccff_shift_en !== v || bs_if.bs_ready !== 1'b1 ||
                ccff_head !== bs_if.bs_data || config_enable !== 1'b1) en_bad++;
            if (ccff_shift_en === 1'b1) shifts++;
            if (v) k++;
            idx++;
            @(negedge prog_clk);
        end
        bs_if.bs_valid = 1'b0;
        load_cycles = idx;
        for (int c = 0; c < 200; c++) begin
            if (cfg_done === 1'b1 || cfg_err !== '0) break;
            if (ccff_shift_en === 1'b1) shifts++;
            start = (c == busy_at);
            @(negedge prog_clk);
        end
        start = 1'b0;
        latency = (cfg_done === 1'b1 || cfg_err !== '0) ? (cyc - t0) : -1;
    endtask

    task automatic test_reset();
        for (int r = 0; r < 2; r++) begin
            @(negedge prog_clk);
            if (r == 1) prog_reset = 1'b0;
            tests++; if (bs_if.bs_ready !== 1'b0) begin failed++; $display("FAIL reset_bs_ready got %b want 0", bs_if.bs_ready); end
            tests++; if (ccff_shift_en !== 1'b0) begin failed++; $display("FAIL reset_shift_en got %b want 0", ccff_shift_en); end
            tests++; if (ccff_head !== '0) begin failed++; $display("FAIL reset_head got %h want 00", ccff_head); end
            tests++; if (config_enable !== 1'b0) begin failed++; $display("FAIL reset_config_enable got %b want 0", config_enable); end
            tests++; if (fabric_reset !== 1'b1) begin failed++; $display("FAIL reset_fabric_reset got %b want 1", fabric_reset); end
            tests++; if (cfg_done !== 1'b0 || cfg_err !== '0) begin failed++; $display("FAIL reset_done_err got %b/%h want 0/00", cfg_done, cfg_err); end
        end
        $display("[TB] reset checks done");
    endtask

    task automatic test_clean_load();
        int lat, sh, eb, lc;
        logic fd;
        new_beats();
        run_seq(0, -1, lat, sh, eb, lc, fd);
        tests++; if (lat != 1 + CL + CL + SC) begin failed++; $display("FAIL clean_latency got %0d want %0d", lat, 1 + CL + CL + SC); end
        tests++; if (sh != 2 * CL) begin failed++; $display("FAIL clean_shifts got %0d want %0d", sh, 2 * CL); end
        tests++; if (eb != 0) begin failed++; $display("FAIL clean_load_outputs bad_cycles %0d want 0", eb); end
        tests++; if (image_bad() != 0) begin failed++; $display("FAIL clean_image bad_chains %0d want 0", image_bad()); end
        repeat (3) @(negedge prog_clk);
        tests++; if (cfg_done !== 1'b1 || fabric_reset !== 1'b0 || config_enable !== 1'b0 || cfg_err !== '0)
            begin failed++; $display("FAIL clean_done_state got done=%b frst=%b cen=%b err=%h want 1/0/0/00", cfg_done, fabric_reset, config_enable, cfg_err); end
        $display("[TB] clean load latency=%0d shifts=%0d", lat, sh);
    endtask

    task automatic test_stalls();
        int lat, sh, eb, lc;
        logic fd;
        new_beats();
        run_seq(1, -1, lat, sh, eb, lc, fd);
        tests++; if (eb != 0) begin failed++; $display("FAIL stall_shift_en bad_cycles %0d want 0", eb); end
        tests++; if (sh != 2 * CL) begin failed++; $display("FAIL stall_shifts got %0d want %0d", sh, 2 * CL); end
        tests++; if (lat != 1 + lc + CL + SC) begin failed++; $display("FAIL stall_latency got %0d want %0d", lat, 1 + lc + CL + SC); end
        tests++; if (image_bad() != 0) begin failed++; $display("FAIL stall_image bad_chains %0d want 0", image_bad()); end
        $display("[TB] stalled load cycles=%0d latency=%0d", lc, lat);
    endtask

    task automatic test_fault();
        int lat, sh, eb, lc;
        logic fd;
        logic [NC-1:0] exp_mask;
        new_beats();
        if (model_par(3) == 1'b0) beats[0][3] = ~beats[0][3];
        stuck = 8'b0000_1000;
        for (int i = 0; i < NC; i++) exp_mask[i] = stuck[i] & model_par(i);
        run_seq(0, -1, lat, sh, eb, lc, fd);
        tests++; if (cfg_err !== exp_mask) begin failed++; $display("FAIL fault_err_mask got %b want %b", cfg_err, exp_mask); end
        tests++; if (lat != 1 + CL + CL) begin failed++; $display("FAIL fault_latency got %0d want %0d", lat, 1 + CL + CL); end
        repeat (4) @(negedge prog_clk);
        tests++; if (cfg_err !== exp_mask || fabric_reset !== 1'b1 || cfg_done !== 1'b0)
            begin failed++; $display("FAIL fault_held got err=%b frst=%b done=%b want %b/1/0", cfg_err, fabric_reset, cfg_done, exp_mask); end
        stuck = '0;
        abort = 1'b1;
        @(negedge prog_clk);
        abort = 1'b0;
        tests++; if (cfg_err !== '0 || fabric_reset !== 1'b1) begin failed++; $display("FAIL fault_abort_clear got err=%b frst=%b want 00/1", cfg_err, fabric_reset); end
        $display("[TB] fault injection err=%b", exp_mask);
    endtask

    task automatic test_abort_mid_load();
        new_beats();
        pulse_start();
        for (int k = 0; k < 5; k++) begin
            bs_if.bs_valid = 1'b1; bs_if.bs_data = beats[k];
            @(negedge prog_clk);
        end
        bs_if.bs_valid = 1'b1; bs_if.bs_data = beats[5];
        start = 1'b1;
        abort = 1'b1;
        @(negedge prog_clk);
        abort = 1'b0; start = 1'b0; bs_if.bs_valid = 1'b0;
        tests++; if (bs_if.bs_ready !== 1'b0 || ccff_shift_en !== 1'b0) begin failed++; $display("FAIL abort_ready got rdy=%b sh=%b want 0/0", bs_if.bs_ready, ccff_shift_en); end
        tests++; if (fabric_reset !== 1'b1 || config_enable !== 1'b0) begin failed++; $display("FAIL abort_outputs got frst=%b cen=%b want 1/0", fabric_reset, config_enable); end
        $display("[TB] abort at beat 5");
    endtask

    task automatic test_back_to_back();
        int lat, sh, eb, lc;
        logic fd;
        new_beats();
        run_seq(0, 3, lat, sh, eb, lc, fd);
        tests++; if (lat != 1 + CL + CL + SC) begin failed++; $display("FAIL busy_latency got %0d want %0d", lat, 1 + CL + CL + SC); end
        tests++; if (image_bad() != 0 || eb != 0) begin failed++; $display("FAIL busy_image bad_chains %0d bad_cycles %0d want 0/0", image_bad(), eb); end
        new_beats();
        run_seq(0, -1, lat, sh, eb, lc, fd);
        tests++; if (fd !== 1'b0) begin failed++; $display("FAIL reload_done_cleared got %b want 0", fd); end
        tests++; if (lat != 1 + CL + CL + SC || image_bad() != 0) begin failed++; $display("FAIL reload_result latency %0d bad_chains %0d want %0d/0", lat, image_bad(), 1 + CL + CL + SC); end
        $display("[TB] start-while-busy and reload latency=%0d", lat);
    endtask

    task automatic test_reset_mid_verify();
        new_beats();
        pulse_start();
        for (int k = 0; k < CL; k++) begin
            bs_if.bs_valid = 1'b1; bs_if.bs_data = beats[k];
            @(negedge prog_clk);
        end
        bs_if.bs_valid = 1'b0;
        repeat (3) @(negedge prog_clk);
        tests++; if (ccff_shift_en !== 1'b1) begin failed++; $display("FAIL rstv_in_verify got shift_en=%b want 1", ccff_shift_en); end
        prog_reset = 1'b1;
        @(negedge prog_clk);
        tests++; if (ccff_shift_en !== 1'b0 || ccff_head !== '0 || bs_if.bs_ready !== 1'b0)
            begin failed++; $display("FAIL rstv_comb got sh=%b head=%h rdy=%b want 0/00/0", ccff_shift_en, ccff_head, bs_if.bs_ready); end
        tests++; if (config_enable !== 1'b0 || fabric_reset !== 1'b1 || cfg_done !== 1'b0 || cfg_err !== '0)
            begin failed++; $display("FAIL rstv_regs got cen=%b frst=%b done=%b err=%h want 0/1/0/00", config_enable, fabric_reset, cfg_done, cfg_err); end
        prog_reset = 1'b0;
        $display("[TB] reset during verify");
    endtask

    initial begin
        bs_if.bs_valid = 1'b0;
        bs_if.bs_data  = '0;
        repeat (3) @(negedge prog_clk);
        test_reset();
        test_clean_load();
        test_stalls();
        test_fault();
        test_abort_mid_load();
        test_back_to_back();
        test_reset_mid_verify();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
